draw_bar_graph: RTL and testbench

- Parametrised VGA pipeline draw stage that renders N_CH vertical voltage bars, each with an optional decaying peak-hold marker, over the incoming pixel stream.
- Sits in the draw chain between the background/rectangle stages and the character/mouse overlay stages.
- Channel values are written at any time into shadow registers and become visible only at a frame boundary, so no bar tears mid-frame.
- Successor to the fixed single-purpose draw stages: channel count, geometry, value width and peak behaviour are all parameters.

---
 rtl/draw_bar_graph.sv | 214 +++++++++++++++++++++
 tb/tb_draw_bar_graph.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_bar_graph.sv
// rtl/draw_bar_graph.sv - draw stage rendering N_CH vertical bars with peak-hold markers
// Two-stage pipeline: column decode, then colour compose against frame-latched values.
module draw_bar_graph #(
   parameter int          N_CH        = 13,
   parameter int          VAL_W       = 12,
   parameter int          H_LOG2      = 8,
   parameter int          XPOS        = 64,
   parameter int          YPOS        = 200,
   parameter int          BAR_W       = 24,
   parameter int          BAR_GAP     = 8,
   parameter int          HOLD_FRAMES = 30,
   parameter int          DECAY       = 2,
   parameter logic [11:0] BAR_RGB     = 12'h0F0,
   parameter logic [11:0] PEAK_RGB    = 12'hF00,
   localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              ch_wr_en,
   input  logic [CH_W-1:0]   ch_wr_addr,
   input  logic [VAL_W-1:0]  ch_wr_data,
   input  logic              peak_en,
   input  logic [11:0]       hcount_in,
   input  logic [11:0]       vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [11:0]       rgb_in,
   output logic [11:0]       hcount_out,
   output logic [11:0]       vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [11:0]       rgb_out,
   output logic              frame_tick
);

   localparam int PITCH  = BAR_W + BAR_GAP;
   localparam int SHIFT  = VAL_W - H_LOG2;
   localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam int Y_BOT  = YPOS + (1 << H_LOG2) - 1;
   localparam int X_END  = XPOS + N_CH * PITCH;

   logic [VAL_W-1:0]  shadow   [N_CH];
   logic [VAL_W-1:0]  active   [N_CH];
   logic [H_LOG2-1:0] peak     [N_CH];
   logic [HOLD_W-1:0] hold     [N_CH];
   logic [H_LOG2-1:0] new_h    [N_CH];
   logic [H_LOG2-1:0] peak_nxt [N_CH];
   logic [HOLD_W-1:0] hold_nxt [N_CH];

   logic vblnk_prev;
   logic frame_upd;
   logic addr_ok;

   function automatic logic [H_LOG2-1:0] height(input logic [VAL_W-1:0] v);
      logic [VAL_W-1:0] s;
      s = v >> SHIFT;
      return s[H_LOG2-1:0];
   endfunction

   assign frame_upd = vblnk_in & ~vblnk_prev;
   assign addr_ok   = ({1'b0, ch_wr_addr} < (CH_W + 1)'(N_CH));

   // Peak tracking uses the height the channel is about to take, i.e. the pre-write shadow.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         new_h[i]    = height(shadow[i]);
         peak_nxt[i] = peak[i];
         hold_nxt[i] = hold[i];
         if (new_h[i] >= peak[i]) begin
            peak_nxt[i] = new_h[i];
            hold_nxt[i] = HOLD_W'(HOLD_FRAMES);
         end else if (hold[i] != '0) begin
            hold_nxt[i] = hold[i] - 1'b1;
         end else if ({1'b0, peak[i]} >= ({1'b0, new_h[i]} + (H_LOG2 + 1)'(DECAY))) begin
            peak_nxt[i] = peak[i] - H_LOG2'(DECAY);
         end else begin
            peak_nxt[i] = new_h[i];
         end
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         vblnk_prev <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
            peak[i]   <= '0;
            hold[i]   <= '0;
         end
      end else begin
         vblnk_prev <= vblnk_in;
         if (frame_upd) begin
            for (int i = 0; i < N_CH; i++) begin
               active[i] <= shadow[i];
               peak[i]   <= peak_nxt[i];
               hold[i]   <= hold_nxt[i];
            end
         end
         if (ch_wr_en && addr_ok) begin
            shadow[ch_wr_addr] <= ch_wr_data;
         end
      end
   end

   logic [11:0]     rel_x;
   logic [11:0]     col_idx;
   logic [11:0]     col_off;
   logic            in_col_d;

   always_comb begin
      rel_x    = hcount_in - 12'(XPOS);
      col_idx  = rel_x / 12'(PITCH);
      col_off  = rel_x % 12'(PITCH);
      in_col_d = (hcount_in >= 12'(XPOS)) && (hcount_in < 12'(X_END)) &&
                 (col_off < 12'(BAR_W));
   end

   logic [11:0]     hcount_s1;
   logic [11:0]     vcount_s1;
   logic            hsync_s1;
   logic            vsync_s1;
   logic            hblnk_s1;
   logic            vblnk_s1;
   logic [11:0]     rgb_s1;
   logic            in_col_s1;
   logic [CH_W-1:0] ch_s1;
   logic            tick_s1;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         hcount_s1 <= '0;
         vcount_s1 <= '0;
         hsync_s1  <= 1'b0;
         vsync_s1  <= 1'b0;
         hblnk_s1  <= 1'b0;
         vblnk_s1  <= 1'b0;
         rgb_s1    <= '0;
         in_col_s1 <= 1'b0;
         ch_s1     <= '0;
         tick_s1   <= 1'b0;
      end else begin
         hcount_s1 <= hcount_in;
         vcount_s1 <= vcount_in;
         hsync_s1  <= hsync_in;
         vsync_s1  <= vsync_in;
         hblnk_s1  <= hblnk_in;
         vblnk_s1  <= vblnk_in;
         rgb_s1    <= rgb_in;
         in_col_s1 <= in_col_d;
         ch_s1     <= col_idx[CH_W-1:0];
         tick_s1   <= frame_upd;
      end
   end

   logic [H_LOG2-1:0] sel_h;
   logic [H_LOG2-1:0] sel_pk;
   logic [11:0]       bar_top;
   logic              is_bar;
   logic              is_pk;
   logic [11:0]       rgb_d;

   always_comb begin
      sel_h  = '0;
      sel_pk = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_s1 == CH_W'(i)) begin
            sel_h  = height(active[i]);
            sel_pk = peak[i];
         end
      end
      bar_top = 12'(Y_BOT) - 12'(sel_h);
      is_bar  = in_col_s1 && (sel_h != '0) && (vcount_s1 > bar_top) &&
                (vcount_s1 <= 12'(Y_BOT));
      is_pk   = peak_en && in_col_s1 && (sel_pk != '0) &&
                (vcount_s1 == (12'(Y_BOT) - 12'(sel_pk) + 12'd1));
      if (hblnk_s1 || vblnk_s1) begin
         rgb_d = rgb_s1;
      end else if (is_pk) begin
         rgb_d = PEAK_RGB;
      end else if (is_bar) begin
         rgb_d = BAR_RGB;
      end else begin
         rgb_d = rgb_s1;
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         hcount_out <= hcount_s1;
         vcount_out <= vcount_s1;
         hsync_out  <= hsync_s1;
         vsync_out  <= vsync_s1;
         hblnk_out  <= hblnk_s1;
         vblnk_out  <= vblnk_s1;
         rgb_out    <= rgb_d;
         frame_tick <= tick_s1;
      end
   end

endmodule

// File: tb/tb_draw_bar_graph.sv
// tb/tb_draw_bar_graph.sv - directed self-checking bench for draw_bar_graph
module tb_draw_bar_graph;

   localparam logic [11:0] BAR  = 12'h0F0;
   localparam logic [11:0] PK   = 12'hF00;
   localparam logic [11:0] PASS = 12'hA5A;

   logic        pclk = 1'b0;
   logic        rst;
   logic        ch_wr_en;
   logic [3:0]  ch_wr_addr;
   logic [11:0] ch_wr_data;
   logic        peak_en;
   logic [11:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;
   logic [11:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;

   logic [11:0] hist_h [0:31];
   logic [11:0] hist_v [0:31];
   logic [3:0]  hist_s [0:31];
   logic [11:0] hist_c [0:31];

   draw_bar_graph dut (
      .pclk(pclk), .rst(rst),
      .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
      .peak_en(peak_en),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .frame_tick(frame_tick)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic probe(input string tag, input logic [11:0] x, input logic [11:0] y,
                        input logic [11:0] exp);
      @(negedge pclk);
      hcount_in = x; vcount_in = y;
      hblnk_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = PASS;
      repeat (2) @(negedge pclk);
      chk(tag, rgb_out, exp);
   endtask

   task automatic write_ch(input logic [3:0] a, input logic [11:0] d);
      @(negedge pclk);
      ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
      @(negedge pclk);
      ch_wr_en = 1'b0;
   endtask

   task automatic frame(input logic do_wr, input logic [3:0] a, input logic [11:0] d);
      @(negedge pclk);
      hblnk_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'h3C3;
      if (do_wr) begin
         ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
      end
      @(negedge pclk);
      ch_wr_en = 1'b0;
      chk("tick_pre", frame_tick, 0);
      @(negedge pclk);
      chk("tick_pulse", frame_tick, 1);
      @(negedge pclk);
      chk("tick_post", frame_tick, 0);
      vblnk_in = 1'b0; hblnk_in = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ch_wr_en = 1'b0; ch_wr_addr = '0; ch_wr_data = '0; peak_en = 1'b0;
      hcount_in = 12'd100; vcount_in = 12'd50; hsync_in = 1'b1; vsync_in = 1'b1;
      hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hFFF;
      repeat (3) @(negedge pclk);
      chk("rst_hcount", hcount_out, 0);
      chk("rst_vcount", vcount_out, 0);
      chk("rst_sync", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
      chk("rst_rgb", rgb_out, 0);
      chk("rst_tick", frame_tick, 0);
      rst = 1'b1;

      // two-cycle latency on a changing stream, no bubbles
      for (int k = 0; k < 24; k++) begin
         @(negedge pclk);
         if (k >= 2) begin
            chk("lat_hcount", hcount_out, hist_h[k-2]);
            chk("lat_vcount", vcount_out, hist_v[k-2]);
            chk("lat_strobes", {hsync_out, vsync_out, hblnk_out, vblnk_out}, hist_s[k-2]);
            chk("lat_rgb", rgb_out, hist_c[k-2]);
         end
         hist_h[k] = 12'(k * 7 + 3);
         hist_v[k] = 12'(k);
         hist_s[k] = 4'(k * 5 + 1);
         hist_c[k] = 12'($urandom_range(0, 4095));
         hcount_in = hist_h[k]; vcount_in = hist_v[k];
         {hsync_in, vsync_in, hblnk_in, vblnk_in} = hist_s[k];
         rgb_in = hist_c[k];
      end
      @(negedge pclk);
      vblnk_in = 1'b0; hblnk_in = 1'b0;

      frame(0, 0, 0);
      frame(0, 0, 0);
      probe("empty_ch0", 12'd64, 12'd455, PASS);

      write_ch(4'd0, 12'hFFF);
      write_ch(4'd12, 12'h080);
      probe("shadow_hidden", 12'd64, 12'd300, PASS);
      frame(0, 0, 0);
      probe("ch0_top", 12'd64, 12'd201, BAR);
      probe("ch0_bot", 12'd87, 12'd455, BAR);
      probe("ch0_above", 12'd64, 12'd200, PASS);
      probe("ch0_below", 12'd64, 12'd456, PASS);
      probe("gap_x88", 12'd88, 12'd300, PASS);
      probe("left_x63", 12'd63, 12'd300, PASS);
      probe("ch12_top", 12'd448, 12'd448, BAR);
      probe("ch12_bot", 12'd471, 12'd455, BAR);
      probe("ch12_above", 12'd448, 12'd447, PASS);
      probe("ch12_right", 12'd472, 12'd450, PASS);

      write_ch(4'd13, 12'hFFF);
      write_ch(4'd15, 12'hFFF);
      frame(0, 0, 0);
      probe("bad_addr_x480", 12'd480, 12'd455, PASS);
      probe("bad_addr_ch5", 12'd224, 12'd455, PASS);
      probe("bad_addr_ch0", 12'd64, 12'd201, BAR);
      probe("bad_addr_ch12", 12'd448, 12'd447, PASS);

      write_ch(4'd3, 12'h400);
      frame(0, 0, 0);
      probe("ch3_h64_top", 12'd160, 12'd392, BAR);
      frame(1, 4'd3, 12'hFFF);
      probe("ch3_old_val", 12'd160, 12'd300, PASS);
      probe("ch3_old_top", 12'd160, 12'd392, BAR);
      frame(0, 0, 0);
      probe("ch3_new_val", 12'd160, 12'd300, BAR);
      probe("ch3_new_top", 12'd160, 12'd201, BAR);

      // peak hold and decay on channel 1
      peak_en = 1'b1;
      write_ch(4'd1, 12'h800);
      frame(0, 0, 0);
      probe("pk_f1_row", 12'd96, 12'd328, PK);
      probe("pk_f1_bar", 12'd119, 12'd329, BAR);
      probe("pk_f1_above", 12'd96, 12'd327, PASS);
      write_ch(4'd1, 12'h000);
      frame(0, 0, 0);
      probe("pk_f2_row", 12'd96, 12'd328, PK);
      probe("pk_f2_nobar", 12'd96, 12'd329, PASS);
      for (int f = 3; f <= 31; f++) frame(0, 0, 0);
      probe("pk_f31_row", 12'd96, 12'd328, PK);
      frame(0, 0, 0);
      probe("pk_f32_row", 12'd96, 12'd330, PK);
      probe("pk_f32_old", 12'd96, 12'd328, PASS);
      frame(0, 0, 0);
      probe("pk_f33_row", 12'd96, 12'd332, PK);
      peak_en = 1'b0;
      probe("pk_disabled", 12'd96, 12'd332, PASS);
      peak_en = 1'b1;
      for (int f = 34; f <= 94; f++) frame(0, 0, 0);
      probe("pk_f94_row", 12'd96, 12'd454, PK);
      probe("pk_f94_nobar", 12'd96, 12'd455, PASS);
      frame(0, 0, 0);
      probe("pk_f95_gone", 12'd96, 12'd454, PASS);
      probe("pk_ch0_row", 12'd64, 12'd201, PK);

      // asynchronous reset in the middle of a line
      @(negedge pclk);
      hcount_in = 12'd64; vcount_in = 12'd300; rgb_in = PASS;
      repeat (2) @(negedge pclk);
      chk("pre_rst_bar", rgb_out, BAR);
      #2 rst = 1'b0;
      #1;
      chk("arst_rgb", rgb_out, 0);
      chk("arst_hcount", hcount_out, 0);
      chk("arst_vcount", vcount_out, 0);
      @(negedge pclk);
      rst = 1'b1;
      probe("post_rst_ch0", 12'd64, 12'd300, PASS);
      probe("post_rst_ch3", 12'd160, 12'd300, PASS);
      probe("post_rst_ch12", 12'd448, 12'd455, PASS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
